// File: rtl/dec_seq_pkg.sv
// Shared types and code helpers for the decoder index sequencer.
// Start/terminal codes depend only on index width and sweep direction.
package dec_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // dn=0 sweeps upward from 0, dn=1 sweeps downward from the all-ones code
  function automatic logic [31:0] start_code(int idx_w, logic dn);
    return dn ? ((32'd1 << idx_w) - 32'd1) : 32'd0;
  endfunction

  function automatic logic [31:0] term_code(int idx_w, logic dn);
    return start_code(idx_w, !dn);
  endfunction

endpackage

// File: rtl/decoder_index_sequencer_dwell_timer.sv
// Counts the cycles an index has been held; expire_o pulses on the last one.
// Holds its count whenever en_i is low, so a paused sweep resumes mid-dwell.
module dwell_timer #(
  parameter int DWELL = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = $clog2(DWELL + 1);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expire_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = expire_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/decoder_index_sequencer.sv
// Sweeps the 4-to-16 decoder select index with per-code dwell, pause and single-step.
// Define DECODE_CHECK_EN to build the sticky one-hot response checker driving err.
module decoder_index_sequencer
  import dec_seq_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int DWELL = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  step,
  input  logic                  dir,
  input  logic                  cont,
  output logic [0:IDX_W-1]      idx,
  output logic                  idx_valid,
  output logic                  busy,
  output logic                  sweep_done,
  input  logic [0:2**IDX_W-1]   dec_i,
  output logic                  err
);

  localparam int N = 2 ** IDX_W;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             dir_q;
  logic             vld_q;
  logic             done_q;

  logic             start_acc;
  logic             tmr_en;
  logic             expire;
  logic [IDX_W-1:0] first_code;
  logic [IDX_W-1:0] wrap_code;
  logic [IDX_W-1:0] last_code;

  assign start_acc  = (state_q == IDLE) && start && !stop;
  assign tmr_en     = (state_q == RUN) && !stop;
  assign first_code = IDX_W'(start_code(IDX_W, dir));
  assign wrap_code  = IDX_W'(start_code(IDX_W, dir_q));
  assign last_code  = IDX_W'(term_code(IDX_W, dir_q));

  dwell_timer #(.DWELL(DWELL)) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (start_acc),
    .en_i     (tmr_en),
    .expire_o (expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dir_q   <= 1'b0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      vld_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // stop outranks start, so start+stop together leaves us idle
          if (!stop) begin
            if (start) begin
              state_q <= RUN;
              dir_q   <= dir;
              idx_q   <= first_code;
              vld_q   <= 1'b1;
            end else if (step) begin
              idx_q <= dir ? idx_q - IDX_W'(1) : idx_q + IDX_W'(1);
              vld_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (stop) begin
            state_q <= PAUSE;
          end else if (expire) begin
            if (idx_q == last_code) begin
              done_q <= 1'b1;
              idx_q  <= wrap_code;
              if (cont) begin
                vld_q <= 1'b1;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              idx_q <= dir_q ? idx_q - IDX_W'(1) : idx_q + IDX_W'(1);
              vld_q <= 1'b1;
            end
          end
        end
        PAUSE: begin
          if (stop) begin
            state_q <= IDLE;
            idx_q   <= '0;
          end else if (start) begin
            state_q <= RUN;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign idx        = idx_q;
  assign idx_valid  = vld_q;
  assign sweep_done = done_q;
  assign busy       = (state_q != IDLE);

`ifdef DECODE_CHECK_EN
  logic [0:N-1] exp_oh;
  logic         err_q;

  always_comb begin
    exp_oh        = '0;
    exp_oh[idx_q] = 1'b1;
  end

  // a fresh sweep clears the flag even if this cycle also mismatches
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (start_acc) begin
      err_q <= 1'b0;
    end else if (exp_oh != dec_i) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_dec;
  assign unused_dec = ^dec_i;
  assign err        = 1'b0;
`endif

endmodule
